// File: rtl/cu_pkg.sv
// Encodings shared by the instruction decoder and its output register.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents: opcode and R-type func constants, ALU op and next-PC select
// encodings, and the packed control bundle carried from decode to the flops.
package cu_pkg;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001010;
  localparam logic [5:0] OP_LOAD  = 6'b001101;
  localparam logic [5:0] OP_STORE = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b001111;
  localparam logic [5:0] OP_BNE   = 6'b010000;
  localparam logic [5:0] OP_JUMP  = 6'b010010;

  // R-type function field, instruction bits [5:0]
  localparam logic [5:0] FN_ADD = 6'b000001;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000011;
  localparam logic [5:0] FN_OR  = 6'b000100;
  localparam logic [5:0] FN_SLL = 6'b000101;
  localparam logic [5:0] FN_SRL = 6'b000110;
  localparam logic [5:0] FN_SRA = 6'b000111;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;

  // Next-PC select
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RSVD   = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // Control bundle; all-zero is the NOP / reset value.
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [2:0] aluc;
    logic       regrt;
    logic       aluimm;
    logic       sext;
    logic       shift;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational op/func/branch-flag decode into the datapath control bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluates every cycle.
//
// Ports: op (6) opcode, func (6) R-type function, rsrtequ (1) rs==rt flag,
//        ctrl_o (ctrl_t) decoded controls.
module control_decode
  import cu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       rsrtequ,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (op)
      OP_RTYPE: begin
        ctrl_o.wreg = 1'b1;
        unique case (func)
          FN_ADD: ctrl_o.aluc = ALU_ADD;
          FN_SUB: ctrl_o.aluc = ALU_SUB;
          FN_AND: ctrl_o.aluc = ALU_AND;
          FN_OR:  ctrl_o.aluc = ALU_OR;
          FN_SLL: begin ctrl_o.aluc = ALU_SLL; ctrl_o.shift = 1'b1; end
          FN_SRL: begin ctrl_o.aluc = ALU_SRL; ctrl_o.shift = 1'b1; end
          FN_SRA: begin ctrl_o.aluc = ALU_SRA; ctrl_o.shift = 1'b1; end
          default: begin
            // Unknown func: squash the write enable set above.
            ctrl_o         = '0;
            ctrl_o.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl_o.wreg   = 1'b1;
        ctrl_o.regrt  = 1'b1;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.sext   = 1'b1;
        ctrl_o.aluc   = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl_o.wreg   = 1'b1;
        ctrl_o.regrt  = 1'b1;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.aluc   = ALU_AND;
      end
      OP_ORI: begin
        ctrl_o.wreg   = 1'b1;
        ctrl_o.regrt  = 1'b1;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.aluc   = ALU_OR;
      end
      OP_LOAD: begin
        ctrl_o.wreg   = 1'b1;
        ctrl_o.m2reg  = 1'b1;
        ctrl_o.regrt  = 1'b1;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.sext   = 1'b1;
        ctrl_o.aluc   = ALU_ADD;
      end
      OP_STORE: begin
        ctrl_o.wmem   = 1'b1;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.sext   = 1'b1;
        ctrl_o.aluc   = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_o.sext     = 1'b1;
        ctrl_o.aluc     = ALU_SUB;
        ctrl_o.pcsource = rsrtequ ? PC_BRANCH : PC_SEQ;
      end
      OP_BNE: begin
        ctrl_o.sext     = 1'b1;
        ctrl_o.aluc     = ALU_SUB;
        ctrl_o.pcsource = rsrtequ ? PC_SEQ : PC_BRANCH;
      end
      OP_JUMP: begin
        ctrl_o.pcsource = PC_JUMP;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main instruction decoder: op/func/rsrtequ decode captured in output flops.
// Latency: 1 cycle from op/func/rsrtequ to every output.
// Backpressure: none; a new decode is registered every clock.
//
// Ports: clk, rst_n (sync, active-low); op, func, rsrtequ in;
//        wreg, m2reg, wmem, aluc, regrt, aluimm, sext, shift, pcsource, illegal out.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       rsrtequ,
  output logic       wreg,
  output logic       m2reg,
  output logic       wmem,
  output logic [2:0] aluc,
  output logic       regrt,
  output logic       aluimm,
  output logic       sext,
  output logic       shift,
  output logic [1:0] pcsource,
  output logic       illegal
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .op      (op),
    .func    (func),
    .rsrtequ (rsrtequ),
    .ctrl_o  (ctrl_d)
  );

  // Reset loads the all-zero NOP bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign wreg     = ctrl_q.wreg;
  assign m2reg    = ctrl_q.m2reg;
  assign wmem     = ctrl_q.wmem;
  assign aluc     = ctrl_q.aluc;
  assign regrt    = ctrl_q.regrt;
  assign aluimm   = ctrl_q.aluimm;
  assign sext     = ctrl_q.sext;
  assign shift    = ctrl_q.shift;
  assign pcsource = ctrl_q.pcsource;
  assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed vector bench for control_unit.
// Latency: outputs checked one rising edge after inputs are applied.
// Backpressure: n/a.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] func;
  logic       rsrtequ;
  logic       wreg, m2reg, wmem, regrt, aluimm, sext, shift, illegal;
  logic [2:0] aluc;
  logic [1:0] pcsource;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .func     (func),
    .rsrtequ  (rsrtequ),
    .wreg     (wreg),
    .m2reg    (m2reg),
    .wmem     (wmem),
    .aluc     (aluc),
    .regrt    (regrt),
    .aluimm   (aluimm),
    .sext     (sext),
    .shift    (shift),
    .pcsource (pcsource),
    .illegal  (illegal)
  );

  // Output word order: wreg m2reg wmem aluc[2:0] regrt aluimm sext shift pcsource[1:0] illegal
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        rsrtequ;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [13:0] e(input logic w, input logic m2r, input logic wm,
                                    input logic [2:0] alu, input logic rt, input logic imm,
                                    input logic sx, input logic sh, input logic [1:0] pc,
                                    input logic ill);
    return {w, m2r, wm, alu, rt, imm, sx, sh, pc, ill};
  endfunction

  function automatic logic [13:0] got();
    return {wreg, m2reg, wmem, aluc, regrt, aluimm, sext, shift, pcsource, illegal};
  endfunction

  task automatic add(input string n, input logic [5:0] o, input logic [5:0] f,
                     input logic r, input logic [13:0] x);
    vec_t v;
    v.name = n; v.op = o; v.func = f; v.rsrtequ = r; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [13:0] x);
    logic [13:0] g;
    g = got();
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %b required %b", n, g, x);
    end
  endtask

  // Drive at negedge, let one rising edge capture, sample at the next negedge.
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic r);
    op = o; func = f; rsrtequ = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //                 w m2 wm aluc   rt im sx sh pc     ill
    add("add",   6'b000000, 6'b000001, 1'b0, e(1,0,0,3'b000,0,0,0,0,2'b00,0));
    add("sub",   6'b000000, 6'b000010, 1'b1, e(1,0,0,3'b001,0,0,0,0,2'b00,0));
    add("and",   6'b000000, 6'b000011, 1'b0, e(1,0,0,3'b010,0,0,0,0,2'b00,0));
    add("or",    6'b000000, 6'b000100, 1'b0, e(1,0,0,3'b011,0,0,0,0,2'b00,0));
    add("sll",   6'b000000, 6'b000101, 1'b0, e(1,0,0,3'b100,0,0,0,1,2'b00,0));
    add("srl",   6'b000000, 6'b000110, 1'b0, e(1,0,0,3'b101,0,0,0,1,2'b00,0));
    add("sra",   6'b000000, 6'b000111, 1'b1, e(1,0,0,3'b110,0,0,0,1,2'b00,0));
    add("rfn0",  6'b000000, 6'b000000, 1'b0, e(0,0,0,3'b000,0,0,0,0,2'b00,1));
    add("rfn38", 6'b000000, 6'b111000, 1'b0, e(0,0,0,3'b000,0,0,0,0,2'b00,1));
    add("addi",  6'b001000, 6'b111000, 1'b0, e(1,0,0,3'b000,1,1,1,0,2'b00,0));
    add("andi",  6'b001001, 6'b000000, 1'b0, e(1,0,0,3'b010,1,1,0,0,2'b00,0));
    add("ori",   6'b001010, 6'b000101, 1'b1, e(1,0,0,3'b011,1,1,0,0,2'b00,0));
    add("load",  6'b001101, 6'b000010, 1'b1, e(1,1,0,3'b000,1,1,1,0,2'b00,0));
    add("store", 6'b001110, 6'b000000, 1'b0, e(0,0,1,3'b000,0,1,1,0,2'b00,0));
    add("beq_t", 6'b001111, 6'b000000, 1'b1, e(0,0,0,3'b001,0,0,1,0,2'b01,0));
    add("beq_n", 6'b001111, 6'b000000, 1'b0, e(0,0,0,3'b001,0,0,1,0,2'b00,0));
    add("bne_t", 6'b010000, 6'b000000, 1'b0, e(0,0,0,3'b001,0,0,1,0,2'b01,0));
    add("bne_n", 6'b010000, 6'b000000, 1'b1, e(0,0,0,3'b001,0,0,1,0,2'b00,0));
    add("jump",  6'b010010, 6'b000001, 1'b1, e(0,0,0,3'b000,0,0,0,0,2'b11,0));
    add("op3f",  6'b111111, 6'b000001, 1'b0, e(0,0,0,3'b000,0,0,0,0,2'b00,1));
    add("op0b",  6'b001011, 6'b000001, 1'b1, e(0,0,0,3'b000,0,0,0,0,2'b00,1));

    // Reset with a load on the inputs: outputs must be NOP after the edge.
    rst_n = 1'b0;
    op = 6'b001101; func = 6'b000000; rsrtequ = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset", 14'd0);

    // Release: the load decode appears on the next edge.
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_load", e(1,1,0,3'b000,1,1,1,0,2'b00,0));

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].func, vecs[i].rsrtequ);
      check(vecs[i].name, vecs[i].exp);
    end

    // Registered output: a new input must not show before the edge.
    step(6'b001110, 6'b000000, 1'b0);
    op = 6'b010010;
    #1;
    check("hold", e(0,0,1,3'b000,0,1,1,0,2'b00,0));
    @(posedge clk);
    @(negedge clk);
    check("jump_after", e(0,0,0,3'b000,0,0,0,0,2'b11,0));

    // Branch flag flipping while op stays beq, cycle by cycle.
    step(6'b001111, 6'b000000, 1'b1);
    rsrtequ = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("beq_flip", e(0,0,0,3'b001,0,0,1,0,2'b00,0));

    // Illegal is only for the cycle it is decoded.
    step(6'b111111, 6'b000000, 1'b0);
    check("ill_on", e(0,0,0,3'b000,0,0,0,0,2'b00,1));
    step(6'b000000, 6'b000011, 1'b0);
    check("ill_off", e(1,0,0,3'b010,0,0,0,0,2'b00,0));

    // Mid-stream reset overrides a valid decode.
    rst_n = 1'b0;
    step(6'b001000, 6'b000000, 1'b0);
    check("reset_mid", 14'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_addi", e(1,0,0,3'b000,1,1,1,0,2'b00,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
